// File: rtl/sent_slow_msg_sched.sv
// SENT slow-channel message scheduler: holds NUM_SLOTS serial messages, picks the
// next pending slot round-robin and hands it to the TX block with valid/ack, then waits for done.
module sent_slow_msg_sched #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SLOT_W    = 2
) (
  input  logic                 clk_tx,
  input  logic                 reset_n_tx,
  input  logic                 enable_i,
  input  logic                 cfg_we_i,
  input  logic [SLOT_W-1:0]    cfg_slot_i,
  input  logic [7:0]           cfg_id_i,
  input  logic [15:0]          cfg_data_i,
  input  logic                 cfg_format_i,
  input  logic                 cfg_config_bit_i,
  input  logic                 cfg_oneshot_i,
  input  logic                 cfg_en_i,
  output logic                 msg_valid_o,
  input  logic                 msg_ack_i,
  input  logic                 msg_done_i,
  output logic [7:0]           id_o,
  output logic [15:0]          data_o,
  output logic                 channel_format_o,
  output logic                 config_bit_o,
  output logic [SLOT_W-1:0]    slot_o,
  output logic [NUM_SLOTS-1:0] slot_en_o,
  output logic [15:0]          msg_count_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_OFFER,
    ST_WAIT_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [7:0]            r_id   [NUM_SLOTS];
  logic [15:0]           r_data [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  r_fmt;
  logic [NUM_SLOTS-1:0]  r_cfg;
  logic [NUM_SLOTS-1:0]  r_os;
  logic [NUM_SLOTS-1:0]  r_en;
  logic [SLOT_W-1:0]     r_ptr;

  logic                  r_valid;
  logic                  r_busy;
  logic [7:0]            r_id_o;
  logic [15:0]           r_data_o;
  logic                  r_fmt_o;
  logic                  r_cfg_o;
  logic [SLOT_W-1:0]     r_slot;
  logic [15:0]           r_count;

  logic                  w_found;
  logic [SLOT_W-1:0]     w_sel;
  logic                  w_latch;
  logic                  w_ack_take;
  logic                  w_done_take;
  logic [7:0]            w_id_m;
  logic [15:0]           w_data_m;
  logic                  w_cfg_m;

  function automatic logic [SLOT_W-1:0] rr_idx(input logic [SLOT_W-1:0] base,
                                                input int unsigned      off);
    int unsigned sum;
    sum = (32'(base) + off) % NUM_SLOTS;
    return SLOT_W'(sum);
  endfunction

  // First enabled slot after the pointer, wrapping back to the pointer itself last
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    for (int unsigned i = 1; i <= NUM_SLOTS; i++) begin
      if (!w_found && r_en[rr_idx(r_ptr, i)]) begin
        w_found = 1'b1;
        w_sel   = rr_idx(r_ptr, i);
      end
    end
  end

  // Field masking by channel format, applied when the slot is latched
  always_comb begin
    w_id_m   = {4'b0, r_id[w_sel][3:0]};
    w_data_m = {8'b0, r_data[w_sel][7:0]};
    w_cfg_m  = 1'b0;
    if (r_fmt[w_sel]) begin
      if (r_cfg[w_sel]) begin
        w_id_m   = {4'b0, r_id[w_sel][3:0]};
        w_data_m = r_data[w_sel];
        w_cfg_m  = 1'b1;
      end else begin
        w_id_m   = r_id[w_sel];
        w_data_m = {4'b0, r_data[w_sel][11:0]};
      end
    end
  end

  always_ff @(posedge clk_tx or negedge reset_n_tx) begin
    if (!reset_n_tx) r_state <= ST_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_ack_take  = 1'b0;
    w_done_take = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (enable_i && (r_en != '0)) w_state_nxt = ST_SELECT;
      end
      ST_SELECT: begin
        if (w_found) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_OFFER;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OFFER: begin
        if (msg_ack_i) begin
          w_ack_take  = 1'b1;
          w_state_nxt = ST_WAIT_DONE;
        end else if (!enable_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (msg_done_i) begin
          w_done_take = 1'b1;
          w_state_nxt = enable_i ? ST_SELECT : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Slot storage; a write in the ack cycle overrides the one-shot auto-disable
  always_ff @(posedge clk_tx or negedge reset_n_tx) begin
    if (!reset_n_tx) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        r_id[i]   <= '0;
        r_data[i] <= '0;
      end
      r_fmt <= '0;
      r_cfg <= '0;
      r_os  <= '0;
      r_en  <= '0;
    end else begin
      if (w_ack_take && r_os[r_slot]) r_en[r_slot] <= 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (cfg_we_i && (cfg_slot_i == SLOT_W'(i))) begin
          r_id[i]   <= cfg_id_i;
          r_data[i] <= cfg_data_i;
          r_fmt[i]  <= cfg_format_i;
          r_cfg[i]  <= cfg_config_bit_i;
          r_os[i]   <= cfg_oneshot_i;
          r_en[i]   <= cfg_en_i;
        end
      end
    end
  end

  always_ff @(posedge clk_tx or negedge reset_n_tx) begin
    if (!reset_n_tx) begin
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_id_o   <= '0;
      r_data_o <= '0;
      r_fmt_o  <= 1'b0;
      r_cfg_o  <= 1'b0;
      r_slot   <= '0;
      r_ptr    <= '0;
      r_count  <= '0;
    end else begin
      r_valid <= (w_state_nxt == ST_OFFER);
      r_busy  <= (w_state_nxt == ST_OFFER) || (w_state_nxt == ST_WAIT_DONE);
      if (w_latch) begin
        r_slot   <= w_sel;
        r_id_o   <= w_id_m;
        r_data_o <= w_data_m;
        r_fmt_o  <= r_fmt[w_sel];
        r_cfg_o  <= w_cfg_m;
      end
      if (w_ack_take)  r_ptr   <= r_slot;
      if (w_done_take) r_count <= r_count + 16'd1;
    end
  end

  assign msg_valid_o      = r_valid;
  assign busy_o           = r_busy;
  assign id_o             = r_id_o;
  assign data_o           = r_data_o;
  assign channel_format_o = r_fmt_o;
  assign config_bit_o     = r_cfg_o;
  assign slot_o           = r_slot;
  assign slot_en_o        = r_en;
  assign msg_count_o      = r_count;

endmodule

// File: tb/tb_sent_slow_msg_sched.sv
// Bench for sent_slow_msg_sched: directed scenarios plus randomized traffic, with
// offers checked by a monitor against a queue of predictions from a slot-table model.
module tb_sent_slow_msg_sched;

  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_slot = '0;
  logic [7:0]  cfg_id = '0;
  logic [15:0] cfg_data = '0;
  logic        cfg_format = 1'b0;
  logic        cfg_config_bit = 1'b0;
  logic        cfg_oneshot = 1'b0;
  logic        cfg_en = 1'b0;
  logic        msg_ack = 1'b0;
  logic        msg_done = 1'b0;

  logic        msg_valid_o;
  logic [7:0]  id_o;
  logic [15:0] data_o;
  logic        channel_format_o;
  logic        config_bit_o;
  logic [1:0]  slot_o;
  logic [3:0]  slot_en_o;
  logic [15:0] msg_count_o;
  logic        busy_o;

  sent_slow_msg_sched #(.NUM_SLOTS(NS), .SLOT_W(2)) dut (
    .clk_tx(clk), .reset_n_tx(reset_n), .enable_i(enable),
    .cfg_we_i(cfg_we), .cfg_slot_i(cfg_slot), .cfg_id_i(cfg_id), .cfg_data_i(cfg_data),
    .cfg_format_i(cfg_format), .cfg_config_bit_i(cfg_config_bit),
    .cfg_oneshot_i(cfg_oneshot), .cfg_en_i(cfg_en),
    .msg_valid_o(msg_valid_o), .msg_ack_i(msg_ack), .msg_done_i(msg_done),
    .id_o(id_o), .data_o(data_o), .channel_format_o(channel_format_o),
    .config_bit_o(config_bit_o), .slot_o(slot_o), .slot_en_o(slot_en_o),
    .msg_count_o(msg_count_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          slot;
    logic [7:0]  id;
    logic [15:0] data;
    logic        fmt;
    logic        cfgb;
  } exp_t;

  exp_t        expq[$];
  exp_t        m_cur;
  int          obs_slots[$];
  bit          rec_slots = 1'b0;
  bit          prev_v = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  logic [7:0]  m_id   [NS];
  logic [15:0] m_data [NS];
  logic [NS-1:0] m_fmt, m_cfg, m_os, m_en;
  int          m_ptr;
  int          m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m_id[i] = '0;
      m_data[i] = '0;
    end
    m_fmt = '0; m_cfg = '0; m_os = '0; m_en = '0;
    m_ptr = 0;
    m_count = 0;
  endfunction

  // Mirror whatever is currently on the config bus into the slot table
  function automatic void model_write_bus();
    m_id[cfg_slot]   = cfg_id;
    m_data[cfg_slot] = cfg_data;
    m_fmt[cfg_slot]  = cfg_format;
    m_cfg[cfg_slot]  = cfg_config_bit;
    m_os[cfg_slot]   = cfg_oneshot;
    m_en[cfg_slot]   = cfg_en;
  endfunction

  task automatic drive_cfg(input int s, input logic [7:0] id, input logic [15:0] d,
                           input logic f, input logic c, input logic os, input logic en);
    cfg_we = 1'b1; cfg_slot = 2'(s); cfg_id = id; cfg_data = d;
    cfg_format = f; cfg_config_bit = c; cfg_oneshot = os; cfg_en = en;
  endtask

  task automatic drive_rand(input int s);
    drive_cfg(s, 8'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0));
  endtask

  task automatic cfg_commit();
    tick();
    cfg_we = 1'b0;
    model_write_bus();
  endtask

  task automatic cfg_write(input int s, input logic [7:0] id, input logic [15:0] d,
                           input logic f, input logic c, input logic os, input logic en);
    drive_cfg(s, id, d, f, c, os, en);
    cfg_commit();
  endtask

  // Next enabled slot after the last transmitted one, with format masking
  task automatic predict(output bit found);
    exp_t e;
    int   s;
    found = 1'b0;
    e = '{0, 8'h0, 16'h0, 1'b0, 1'b0};
    for (int off = 1; off <= NS; off++) begin
      s = (m_ptr + off) % NS;
      if (!found && m_en[s]) begin
        found  = 1'b1;
        e.slot = s;
        e.fmt  = m_fmt[s];
        if (!m_fmt[s]) begin
          e.id = m_id[s] & 8'h0F; e.data = m_data[s] & 16'h00FF; e.cfgb = 1'b0;
        end else if (!m_cfg[s]) begin
          e.id = m_id[s]; e.data = m_data[s] & 16'h0FFF; e.cfgb = 1'b0;
        end else begin
          e.id = m_id[s] & 8'h0F; e.data = m_data[s]; e.cfgb = 1'b1;
        end
      end
    end
    if (found) begin
      expq.push_back(e);
      m_cur = e;
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (msg_valid_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("offer_seen", 32'(ok), 32'd1);
  endtask

  // Raise enable from IDLE: offer must appear exactly two cycles later
  task automatic enable_and_expect();
    bit f;
    enable = 1'b1;
    predict(f);
    tick();
    check("idle_latency_low", 32'(msg_valid_o), 32'd0);
    tick();
    check("idle_latency_high", 32'(msg_valid_o), 32'(f));
  endtask

  task automatic drop_enable();
    enable = 1'b0;
    tick();
  endtask

  // One handshake + completion; mode 1 random writes, 2 RR arming, 3 rewrite, 4 enable drop
  task automatic serve(input int mode, output bit found);
    bit ok, same_wr;
    int s;
    found = 1'b0;
    wait_valid(ok);
    if (!ok) return;
    repeat ($urandom_range(0, 3)) tick();
    s = m_cur.slot;
    same_wr = (mode == 1) && ($urandom_range(0, 3) == 0);
    msg_ack = 1'b1;
    if (same_wr) drive_rand(s);
    tick();
    msg_ack = 1'b0;
    cfg_we = 1'b0;
    m_ptr = s;
    if (m_os[s]) m_en[s] = 1'b0;
    if (same_wr) model_write_bus();
    check("valid_after_ack", 32'(msg_valid_o), 32'd0);
    check("slot_en_after_ack", 32'(slot_en_o), 32'(m_en));
    check("busy_in_flight", 32'(busy_o), 32'd1);
    case (mode)
      1: repeat ($urandom_range(0, 3)) begin
           drive_rand($urandom_range(0, NS - 1));
           cfg_commit();
         end
      2: begin
           cfg_write(1, 8'h31, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b1);
           cfg_write(3, 8'h73, 16'h0303, 1'b0, 1'b0, 1'b0, 1'b1);
         end
      3: cfg_write(0, 8'h21, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b1);
      4: enable = 1'b0;
      default: ;
    endcase
    repeat ($urandom_range(1, 5)) tick();
    check("hold_slot", 32'(slot_o), 32'(s));
    check("hold_id", 32'(id_o), 32'(m_cur.id));
    check("hold_data", 32'(data_o), 32'(m_cur.data));
    check("slot_en_in_flight", 32'(slot_en_o), 32'(m_en));
    msg_done = 1'b1;
    m_count = (m_count + 1) & 32'hFFFF;
    if (enable) predict(found);
    tick();
    msg_done = 1'b0;
    check("count_after_done", 32'(msg_count_o), 32'(m_count));
    check("valid_select_gap", 32'(msg_valid_o), 32'd0);
    tick();
    check("valid_after_done", 32'(msg_valid_o), 32'(found));
  endtask

  // Monitor: every new offer must match the oldest outstanding prediction
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_v = 1'b0;
    end else begin
      if (msg_valid_o && !prev_v) begin
        if (expq.size() == 0) begin
          check("unexpected_offer_slot", 32'(slot_o), 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          check("offer_slot", 32'(slot_o), 32'(e.slot));
          check("offer_id", 32'(id_o), 32'(e.id));
          check("offer_data", 32'(data_o), 32'(e.data));
          check("offer_format", 32'(channel_format_o), 32'(e.fmt));
          check("offer_config_bit", 32'(config_bit_o), 32'(e.cfgb));
        end
        if (rec_slots) obs_slots.push_back(int'(slot_o));
      end
      prev_v = msg_valid_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit f, ok;
    model_reset();
    #3;
    check("rst_valid", 32'(msg_valid_o), 32'd0);
    check("rst_slot_en", 32'(slot_en_o), 32'd0);
    check("rst_count", 32'(msg_count_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_id", 32'(id_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Round-robin: slot 0 first, then 1 and 3 armed while slot 0 is in flight
    rec_slots = 1'b1;
    enable = 1'b1;
    cfg_write(0, 8'h10, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1);
    predict(f);
    serve(2, f);
    repeat (4) serve(0, f);
    tick();
    rec_slots = 1'b0;
    check("rr_count", 32'(msg_count_o), 32'd5);
    check("rr_obs_len", 32'(obs_slots.size() >= 5), 32'd1);
    if (obs_slots.size() >= 5) begin
      check("rr_seq0", 32'(obs_slots[0]), 32'd0);
      check("rr_seq1", 32'(obs_slots[1]), 32'd1);
      check("rr_seq2", 32'(obs_slots[2]), 32'd3);
      check("rr_seq3", 32'(obs_slots[3]), 32'd0);
      check("rr_seq4", 32'(obs_slots[4]), 32'd1);
    end

    // Enable drop while offering: valid low next cycle, nothing counted
    drop_enable();
    check("drop_offer_valid", 32'(msg_valid_o), 32'd0);
    check("drop_offer_busy", 32'(busy_o), 32'd0);
    check("drop_offer_count", 32'(msg_count_o), 32'd5);

    // Masking of id/data in the three format variants
    cfg_write(0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cfg_write(1, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cfg_write(3, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cfg_write(2, 8'hAB, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
    enable_and_expect();
    check("mask_short_id", 32'(id_o), 32'h0B);
    check("mask_short_data", 32'(data_o), 32'h0034);
    drop_enable();
    cfg_write(2, 8'hAB, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1);
    enable_and_expect();
    check("mask_enh0_id", 32'(id_o), 32'hAB);
    check("mask_enh0_data", 32'(data_o), 32'h0234);
    drop_enable();
    cfg_write(2, 8'hAB, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b1);
    enable_and_expect();
    check("mask_enh1_id", 32'(id_o), 32'h0B);
    check("mask_enh1_data", 32'(data_o), 32'h1234);
    check("mask_enh1_cfg", 32'(config_bit_o), 32'd1);
    serve(0, f);

    // One-shot slot: single transmission, then idle
    drop_enable();
    cfg_write(2, 8'hAB, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0);
    cfg_write(1, 8'h55, 16'hAAAA, 1'b1, 1'b0, 1'b1, 1'b1);
    enable_and_expect();
    serve(0, f);
    check("oneshot_en_cleared", 32'(slot_en_o), 32'd0);
    repeat (4) tick();
    check("oneshot_no_reoffer", 32'(msg_valid_o), 32'd0);
    check("oneshot_idle", 32'(busy_o), 32'd0);

    // In-flight rewrite keeps outputs; new contents show on the next offer
    cfg_write(0, 8'h21, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b1);
    predict(f);
    serve(3, f);
    check("rewrite_next_data", 32'(data_o), 32'h5555);
    check("rewrite_next_id", 32'(id_o), 32'h01);

    // Enable drop during WAIT_DONE: completion still counted, then idle
    serve(4, f);
    check("drop_wait_count", 32'(msg_count_o), 32'd9);
    repeat (3) tick();
    check("drop_wait_valid", 32'(msg_valid_o), 32'd0);
    check("drop_wait_busy", 32'(busy_o), 32'd0);

    // Randomized traffic
    enable_and_expect();
    for (int n = 0; n < 40; n++) begin
      serve(1, f);
      if (!f) begin
        drive_rand($urandom_range(0, NS - 1));
        cfg_en = 1'b1;
        cfg_commit();
        predict(f);
      end
    end

    // Asynchronous reset in the middle of an offer
    wait_valid(ok);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(msg_valid_o), 32'd0);
    check("async_rst_slot_en", 32'(slot_en_o), 32'd0);
    check("async_rst_count", 32'(msg_count_o), 32'd0);
    check("async_rst_busy", 32'(busy_o), 32'd0);
    model_reset();
    expq.delete();
    enable = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_slot_en", 32'(slot_en_o), 32'd0);
    check("post_rst_data", 32'(data_o), 32'd0);
    check("scoreboard_drained", 32'(expq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sent_slow_msg_sched.md
Name: sent_slow_msg_sched

Overview:
- Slow-channel (serial message) scheduler for the SENT transmitter.
- Holds NUM_SLOTS configurable serial messages (ID + data + format) and picks the next pending slot by round-robin.
- Hands the chosen message to the SENT TX block with a valid/ack handshake, then waits for that message to complete before offering the next one.
- Sits between the register block (config writes, already synchronised to clk_tx) and sent_tx_top's id/data/format inputs.

Parameters:
- NUM_SLOTS, 4, number of message slots (2..8).
- SLOT_W, 2, slot index width; equals clog2(NUM_SLOTS).

Ports:
- clk_tx  in  1  transmit clock; all logic on its rising edge.
- reset_n_tx  in  1  asynchronous active-low reset.
- enable_i  in  1  global scheduler enable.
- cfg_we_i  in  1  slot write strobe; one cycle per write.
- cfg_slot_i  in  SLOT_W  target slot of the write.
- cfg_id_i  in  8  message ID.
- cfg_data_i  in  16  message data.
- cfg_format_i  in  1  channel format: 0 = short serial, 1 = enhanced.
- cfg_config_bit_i  in  1  enhanced config bit.
- cfg_oneshot_i  in  1  1 = slot auto-disables after one transmission.
- cfg_en_i  in  1  slot enable written with the fields.
- msg_valid_o  out  1  offered message valid.
- msg_ack_i  in  1  TX latched the message; transfer occurs on valid & ack.
- msg_done_i  in  1  one-cycle pulse: TX finished the last frame of the message.
- id_o  out  8  offered ID, masked.
- data_o  out  16  offered data, masked.
- channel_format_o  out  1  offered format.
- config_bit_o  out  1  offered config bit.
- slot_o  out  SLOT_W  slot index of the offered or in-flight message.
- slot_en_o  out  NUM_SLOTS  per-slot enable bitmap.
- msg_count_o  out  16  completed-message counter.
- busy_o  out  1  high in OFFER or WAIT_DONE.

Behaviour:
- Reset: every slot field = 0, all slot enables = 0; all outputs = 0; RR pointer = 0; state = IDLE.
- FSM states: IDLE, SELECT, OFFER, WAIT_DONE.
  - IDLE -> SELECT when enable_i = 1 and slot_en_o != 0.
  - SELECT, 1 cycle: search slots starting at ptr+1 (mod NUM_SLOTS) for the first enabled one. If found: latch the slot's fields into the output registers and go to OFFER. If none is found (disabled by a write in the same cycle): go to IDLE.
  - OFFER: msg_valid_o = 1; output fields are stable, from the latched copy. On msg_ack_i: ptr <= slot_o; if the slot is one-shot, clear its enable; go to WAIT_DONE, with msg_valid_o low the next cycle. If enable_i falls before ack: go to IDLE, msg_valid_o low the next cycle, ptr unchanged.
  - WAIT_DONE: on msg_done_i: msg_count_o += 1 (wraps 0xFFFF -> 0); go to SELECT if enable_i, else IDLE. enable_i falling here does not abort the message. A msg_done_i outside WAIT_DONE is ignored.
- Latency: IDLE with a pending slot -> msg_valid_o high after 2 cycles. done -> next msg_valid_o high after 2 cycles.
- Masking, applied at latch:
  - Short format: id_o = {4'b0, id[3:0]}, data_o = {8'b0, data[7:0]}, config_bit_o = 0.
  - Enhanced, config 0: id_o = id[7:0], data_o = {4'b0, data[11:0]}.
  - Enhanced, config 1: id_o = {4'b0, id[3:0]}, data_o = data[15:0].
- Config writes:
  - Update the slot immediately, including its enable.
  - A write to the slot currently offered or in flight does not change the outputs; the new contents apply on its next selection.
- Simultaneous write and ack to a one-shot slot: the write's cfg_en_i wins (slot re-armed if cfg_en_i = 1).
- cfg_slot_i >= NUM_SLOTS: write ignored.
- A mid-operation reset returns everything to reset values immediately, regardless of state.

Test Plan:
- Round-robin: slots 0, 1, 3 enabled and periodic, TX acks next cycle, done 20 cycles later -> slot_o sequence 0, 1, 3, 0, 1; msg_count_o = 5 after 5 dones.
- Masking: slot 2 = id 0xAB, data 0x1234, short format -> id_o = 0x0B, data_o = 0x0034. Same slot enhanced with config 0 -> 0xAB / 0x0234. Enhanced with config 1 -> 0x0B / 0x1234.
- One-shot: slot 1 one-shot, only slot enabled -> one offer; after ack slot_en_o[1] = 0; after done, FSM back in IDLE and msg_valid_o stays 0.
- Enable drop: deassert enable_i during OFFER -> msg_valid_o low next cycle, no count. Deassert during WAIT_DONE -> done still counted, then IDLE.
- In-flight rewrite: write slot 0 data 0x5555 while slot 0 is in WAIT_DONE -> data_o keeps its old value; next offer of slot 0 shows 0x5555 (masked per format).
- Reset: assert reset_n_tx low during OFFER -> msg_valid_o, slot_en_o and msg_count_o read 0 without waiting for a clock edge.
